// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write path.
// The write-request struct is what writeback producers hand to the arbiter.
package regfile_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    // Hardwired zero register: never written, never pending.
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on a tie the port that did not win last is granted.
// The last-grant pointer moves only when a grant is taken (adv_i high).
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] valid_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic last_gnt_q;
    logic last_gnt_d;

    // Reset to 1 so port 0 takes the first tie.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    always_comb begin
        gnt_o = 2'b00;
        unique case (valid_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_gnt_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (adv_i && (gnt_o != 2'b00)) begin
            last_gnt_d = gnt_o[1];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, and keeps
// a pending-write scoreboard that raises RAW hazard flags for the decode reads.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0Valid,
    input  logic [ADDR_W-1:0] Req0Reg,
    input  logic [DATA_W-1:0] Req0Data,
    output logic              Req0Ready,
    input  logic              Req1Valid,
    input  logic [ADDR_W-1:0] Req1Reg,
    input  logic [DATA_W-1:0] Req1Data,
    output logic              Req1Ready,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueReg,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic              HazA,
    output logic              HazB,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              RegWr,
    output logic [31:0]       Pending
);

    wr_req_t     req0;
    wr_req_t     req1;
    wr_req_t     sel;
    logic [1:0]  gnt;
    logic [1:0]  ready;
    logic        take;

    logic [ADDR_W-1:0] rw_q,    rw_d;
    logic [DATA_W-1:0] busw_q,  busw_d;
    logic              regwr_q, regwr_d;
    logic [31:0]       pend_q,  pend_d;

    assign req0 = '{valid: Req0Valid, rd: Req0Reg, data: Req0Data};
    assign req1 = '{valid: Req1Valid, rd: Req1Reg, data: Req1Data};

    rr_arb2 u_arb (
        .clk_i   (Clk),
        .rst_n_i (Rst_n),
        .valid_i ({req1.valid, req0.valid}),
        .adv_i   (Rst_n),
        .gnt_o   (gnt)
    );

    // No handshake can complete on a reset edge, so Ready is held low.
    assign ready     = gnt & {2{Rst_n}};
    assign Req0Ready = ready[0];
    assign Req1Ready = ready[1];

    assign sel  = ready[1] ? req1 : req0;
    assign take = (ready != 2'b00) && sel.valid;

    always_comb begin
        rw_d    = rw_q;
        busw_d  = busw_q;
        regwr_d = 1'b0;
        if (take) begin
            rw_d    = sel.rd;
            busw_d  = sel.data;
            regwr_d = (sel.rd != ZERO_REG);
        end
    end

    // Clear of the retiring write is applied first so a same-cycle issue wins.
    always_comb begin
        pend_d = pend_q;
        if (regwr_q) begin
            pend_d[rw_q] = 1'b0;
        end
        if (IssueValid && (IssueReg != ZERO_REG)) begin
            pend_d[IssueReg] = 1'b1;
        end
        pend_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rw_q    <= '0;
            busw_q  <= '0;
            regwr_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            rw_q    <= rw_d;
            busw_q  <= busw_d;
            regwr_q <= regwr_d;
            pend_q  <= pend_d;
        end
    end

    assign RW      = rw_q;
    assign BusW    = busw_q;
    assign RegWr   = regwr_q;
    assign Pending = pend_q;

    assign HazA = (RA != ZERO_REG) && pend_q[RA];
    assign HazB = (RB != ZERO_REG) && pend_q[RB];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a behavioural
// model of the grant rules, write stage, scoreboard and register file contents.
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Req0Valid, Req1Valid;
    logic [4:0]  Req0Reg, Req1Reg;
    logic [63:0] Req0Data, Req1Data;
    logic        Req0Ready, Req1Ready;
    logic        IssueValid;
    logic [4:0]  IssueReg, RA, RB;
    logic        HazA, HazB;
    logic [4:0]  RW;
    logic [63:0] BusW;
    logic        RegWr;
    logic [31:0] Pending;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    bit          m_last;
    bit [31:0]   m_pend;
    logic [4:0]  m_rw;
    logic [63:0] m_busw;
    bit          m_regwr;
    logic [1:0]  last_g;
    logic [63:0] m_rf [32] = '{default: '0};

    // Register file harness: writes at the negedge, reg 31 is hardwired zero
    logic [63:0] rf [32] = '{default: '0};

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (RegWr === 1'b1 && RW !== 5'd31) rf[RW] <= BusW;
    end

    regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .Req0Valid(Req0Valid), .Req0Reg(Req0Reg), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
        .Req1Valid(Req1Valid), .Req1Reg(Req1Reg), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
        .IssueValid(IssueValid), .IssueReg(IssueReg), .RA(RA), .RB(RB),
        .HazA(HazA), .HazB(HazB), .RW(RW), .BusW(BusW), .RegWr(RegWr), .Pending(Pending)
    );

    function automatic logic [1:0] exp_gnt();
        if (!Rst_n) return 2'b00;
        if (Req0Valid && Req1Valid) return m_last ? 2'b01 : 2'b10;
        return {Req1Valid, Req0Valid};
    endfunction

    function automatic bit exp_haz(input logic [4:0] a);
        return (a != 5'd31) && m_pend[a];
    endfunction

    // Advance one clock and apply the rules to the model.
    task automatic tick();
        logic [1:0]  g;
        logic [4:0]  r, ir;
        logic [63:0] d;
        bit          rst, iv;
        bit [31:0]   np;
        g   = exp_gnt();
        rst = !Rst_n;
        iv  = IssueValid;
        ir  = IssueReg;
        r   = g[1] ? Req1Reg : Req0Reg;
        d   = g[1] ? Req1Data : Req0Data;
        @(posedge Clk);
        if (rst) begin
            m_rw = '0; m_busw = '0; m_regwr = 1'b0; m_pend = '0; m_last = 1'b1;
        end else begin
            np = m_pend;
            if (m_regwr) np[m_rw] = 1'b0;
            if (iv && ir != 5'd31) np[ir] = 1'b1;
            m_pend = np;
            if (g != 2'b00) begin
                m_last  = g[1];
                m_rw    = r;
                m_busw  = d;
                m_regwr = (r != 5'd31);
                if (m_regwr) m_rf[r] = d;
            end else begin
                m_regwr = 1'b0;
            end
        end
        last_g = g;
        #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; Req0Valid = 1'b1; Req1Valid = 1'b1;
        Req0Reg = 5'd1; Req0Data = 64'h11; Req1Reg = 5'd2; Req1Data = 64'h22;
        IssueValid = 1'b0; IssueReg = '0; RA = '0; RB = '0;
        #1;
        vectors++;
        if ({Req1Ready, Req0Ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 00", {Req1Ready, Req0Ready});
        end
        tick();
        tick();
        vectors++;
        if ({RW, BusW, RegWr, Pending} !== {5'd0, 64'd0, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got RW=%0d BusW=%h RegWr=%b Pending=%h", RW, BusW, RegWr, Pending);
        end
        Rst_n = 1'b1;
        #1;
        vectors++;
        if ({Req1Ready, Req0Ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_first_tie: got %b want 01", {Req1Ready, Req0Ready});
        end
        tick();
        vectors++;
        if ({RW, BusW, RegWr, Pending} !== {m_rw, m_busw, m_regwr, m_pend}) begin
            miscompares++;
            $display("FAIL reset_first_write: got RW=%0d BusW=%h RegWr=%b want RW=%0d BusW=%h RegWr=%b",
                     RW, BusW, RegWr, m_rw, m_busw, m_regwr);
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
    endtask

    task automatic test_contention();
        logic [1:0] prev;
        Req0Valid = 1'b1; Req0Reg = 5'd3; Req0Data = 64'hA;
        Req1Valid = 1'b1; Req1Reg = 5'd4; Req1Data = 64'hB;
        prev = 2'b00;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if ({Req1Ready, Req0Ready} !== exp_gnt() || {Req1Ready, Req0Ready} === prev) begin
                miscompares++;
                $display("FAIL contention_grant[%0d]: got %b want %b", i, {Req1Ready, Req0Ready}, exp_gnt());
            end
            prev = {Req1Ready, Req0Ready};
            tick();
            vectors++;
            if ({RW, BusW, RegWr} !== {m_rw, m_busw, 1'b1}) begin
                miscompares++;
                $display("FAIL contention_write[%0d]: got RW=%0d BusW=%h RegWr=%b want RW=%0d BusW=%h RegWr=1",
                         i, RW, BusW, RegWr, m_rw, m_busw);
            end
        end
        Req0Valid = 1'b0; Req1Valid = 1'b0;
        @(negedge Clk); #1;
        vectors++;
        if ({rf[3], rf[4]} !== {64'hA, 64'hB}) begin
            miscompares++;
            $display("FAIL contention_rf: got r3=%h r4=%h want r3=a r4=b", rf[3], rf[4]);
        end
    endtask

    task automatic test_zero_reg();
        Req1Valid = 1'b1; Req1Reg = 5'd31; Req1Data = 64'hFFFF;
        IssueValid = 1'b1; IssueReg = 5'd31;
        #1;
        vectors++;
        if ({Req1Ready, Req0Ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL zero_ready: got %b want 10", {Req1Ready, Req0Ready});
        end
        tick();
        Req1Valid = 1'b0; IssueValid = 1'b0;
        vectors++;
        if (RegWr !== 1'b0 || Pending[31] !== 1'b0 || Pending !== m_pend) begin
            miscompares++;
            $display("FAIL zero_nowrite: got RegWr=%b Pending=%h want RegWr=0 Pending=%h", RegWr, Pending, m_pend);
        end
        @(negedge Clk); #1;
        vectors++;
        if (rf[31] !== 64'd0) begin
            miscompares++;
            $display("FAIL zero_rf: got r31=%h want 0", rf[31]);
        end
    endtask

    task automatic test_scoreboard();
        IssueValid = 1'b1; IssueReg = 5'd7; RA = 5'd7; RB = 5'd31;
        #1;
        tick();
        IssueValid = 1'b0;
        #1;
        vectors++;
        if (HazA !== 1'b1 || HazA !== exp_haz(RA) || HazB !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_set: got HazA=%b HazB=%b want HazA=1 HazB=0", HazA, HazB);
        end
        Req0Valid = 1'b1; Req0Reg = 5'd7; Req0Data = 64'h77;
        tick();
        Req0Valid = 1'b0;
        #1;
        vectors++;
        if (HazA !== 1'b1 || RegWr !== 1'b1 || RW !== 5'd7) begin
            miscompares++;
            $display("FAIL sb_during_write: got HazA=%b RegWr=%b RW=%0d want 1 1 7", HazA, RegWr, RW);
        end
        tick();
        vectors++;
        if (HazA !== 1'b0 || HazA !== exp_haz(RA) || Pending !== m_pend) begin
            miscompares++;
            $display("FAIL sb_clear: got HazA=%b Pending=%h want HazA=0 Pending=%h", HazA, Pending, m_pend);
        end
    endtask

    task automatic test_collision();
        IssueValid = 1'b1; IssueReg = 5'd5;
        tick();
        IssueValid = 1'b0;
        Req0Valid = 1'b1; Req0Reg = 5'd5; Req0Data = 64'h5555;
        tick();
        Req0Valid = 1'b0;
        IssueValid = 1'b1; IssueReg = 5'd5;
        tick();
        IssueValid = 1'b0;
        vectors++;
        if (Pending[5] !== 1'b1 || Pending !== m_pend) begin
            miscompares++;
            $display("FAIL collision_pending: got Pending=%h want bit5 set, %h", Pending, m_pend);
        end
    endtask

    task automatic test_stall();
        Req1Valid = 1'b1; Req1Reg = 5'd2; Req1Data = 64'h2;
        tick();
        Req0Valid = 1'b1; Req0Reg = 5'd8;  Req0Data = 64'h88;
        Req1Valid = 1'b1; Req1Reg = 5'd9;  Req1Data = 64'h55;
        #1;
        vectors++;
        if ({Req1Ready, Req0Ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL stall_tie: got %b want 01", {Req1Ready, Req0Ready});
        end
        tick();
        Req0Valid = 1'b0;
        #1;
        vectors++;
        if ({Req1Ready, Req0Ready} !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_regrant: got %b want 10", {Req1Ready, Req0Ready});
        end
        tick();
        Req1Valid = 1'b0;
        vectors++;
        if ({RW, BusW, RegWr} !== {5'd9, 64'h55, 1'b1}) begin
            miscompares++;
            $display("FAIL stall_write: got RW=%0d BusW=%h RegWr=%b want 9 55 1", RW, BusW, RegWr);
        end
    endtask

    task automatic test_random();
        bit was_rst;
        was_rst = 1'b1;
        last_g  = 2'b11;
        for (int i = 0; i < 400; i++) begin
            if (was_rst || !Req0Valid || last_g[0]) begin
                Req0Valid = ($urandom_range(0, 2) != 0);
                Req0Reg   = 5'($urandom_range(0, 31));
                Req0Data  = {$urandom, $urandom};
            end
            if (was_rst || !Req1Valid || last_g[1]) begin
                Req1Valid = ($urandom_range(0, 2) != 0);
                Req1Reg   = 5'($urandom_range(0, 31));
                Req1Data  = {$urandom, $urandom};
            end
            IssueValid = ($urandom_range(0, 1) != 0);
            IssueReg   = 5'($urandom_range(0, 31));
            RA         = 5'($urandom_range(0, 31));
            RB         = 5'($urandom_range(0, 31));
            Rst_n      = ($urandom_range(0, 49) != 0);
            was_rst    = !Rst_n;
            #1;
            vectors++;
            if ({Req1Ready, Req0Ready, HazA, HazB} !== {exp_gnt(), exp_haz(RA), exp_haz(RB)}) begin
                miscompares++;
                $display("FAIL rand_comb[%0d]: got rdy=%b haz=%b%b want rdy=%b haz=%b%b", i,
                         {Req1Ready, Req0Ready}, HazA, HazB, exp_gnt(), exp_haz(RA), exp_haz(RB));
            end
            tick();
            vectors++;
            if ({RW, BusW, RegWr, Pending} !== {m_rw, m_busw, m_regwr, m_pend}) begin
                miscompares++;
                $display("FAIL rand_regs[%0d]: got RW=%0d BusW=%h RegWr=%b Pending=%h want RW=%0d BusW=%h RegWr=%b Pending=%h",
                         i, RW, BusW, RegWr, Pending, m_rw, m_busw, m_regwr, m_pend);
            end
            @(negedge Clk); #1;
            vectors++;
            if (rf[m_rw] !== m_rf[m_rw]) begin
                miscompares++;
                $display("FAIL rand_rf[%0d]: reg %0d got %h want %h", i, m_rw, rf[m_rw], m_rf[m_rw]);
            end
        end
        Rst_n = 1'b1; Req0Valid = 1'b0; Req1Valid = 1'b0; IssueValid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_last = 1'b1; m_pend = '0; m_rw = '0; m_busw = '0; m_regwr = 1'b0; last_g = '0;
        test_reset();
        test_contention();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
